// File: rtl/pc_fetch_pkg.sv
// Shared fetch-front-end definitions: state encoding and default address width
// (the same width is used by branch_adder and the instruction memory).
package pc_fetch_pkg;

    localparam int INST_ADDR_WIDTH_DEF = 9;

    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'd0,
        FETCH_RUN    = 2'd1,
        FETCH_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_pc_next_mux.sv
// Combinational instruction-memory address selection.
// Outside RUN the BRAM is parked on RESET_PC; in RUN a redirect beats a stall,
// and the sequential increment wraps modulo 2^W.
module pc_next_mux #(
    parameter int W        = 9,
    parameter int RESET_PC = 0
) (
    input  logic         run_i,
    input  logic         branch_taken_i,
    input  logic [W-1:0] branch_target_i,
    input  logic         stall_i,
    input  logic [W-1:0] fetch_pc_i,
    output logic [W-1:0] imem_addr_o
);

    localparam logic [W-1:0] RESET_PC_V = W'(RESET_PC);
    localparam logic [W-1:0] ONE        = {{(W-1){1'b0}}, 1'b1};

    // Priority select of the next BRAM read address
    always_comb begin
        imem_addr_o = RESET_PC_V;
        if (run_i) begin
            if (branch_taken_i)
                imem_addr_o = branch_target_i;
            else if (stall_i)
                imem_addr_o = fetch_pc_i;          // re-read same word
            else
                imem_addr_o = fetch_pc_i + ONE;    // natural wrap at max
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the BRAM address, tracks
// which PC is on the BRAM data bus (1-cycle read latency) and counts delivered
// instructions.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int INST_ADDR_WIDTH = INST_ADDR_WIDTH_DEF,
    parameter int RESET_PC        = 0,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       halt,
    input  logic                       stall,
    input  logic                       branch_taken,
    input  logic [INST_ADDR_WIDTH-1:0] branch_target,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr,
    output logic [INST_ADDR_WIDTH-1:0] fetch_pc,
    output logic                       fetch_valid,
    output logic                       flush,
    output logic                       running,
    output logic [CNT_WIDTH-1:0]       fetch_count
);

    localparam logic [INST_ADDR_WIDTH-1:0] RESET_PC_V = INST_ADDR_WIDTH'(RESET_PC);
    localparam logic [CNT_WIDTH-1:0]       CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_e               state_q, state_d;
    logic [INST_ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                       fetch_valid_q, fetch_valid_d;
    logic [CNT_WIDTH-1:0]       count_q, count_d;

    pc_next_mux #(
        .W        (INST_ADDR_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_next_mux (
        .run_i           (running),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .stall_i         (stall),
        .fetch_pc_i      (fetch_pc_q),
        .imem_addr_o     (imem_addr)
    );

    // State and datapath registers; reset beats every input
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH_IDLE;
            fetch_pc_q    <= RESET_PC_V;
            fetch_valid_q <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            count_q       <= count_d;
        end
    end

    // Next-state: start leaves IDLE/HALTED, halt leaves RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_IDLE, FETCH_HALTED: if (start) state_d = FETCH_RUN;
            FETCH_RUN:                if (halt)  state_d = FETCH_HALTED;
            default:                             state_d = FETCH_IDLE;
        endcase
    end

    // State-decoded outputs; a halt in the same cycle suppresses the flush
    always_comb begin
        running = (state_q == FETCH_RUN);
        flush   = running & branch_taken & ~halt;
    end

    // PC / valid / counter next values. A stall needs no special case: the mux
    // already returns fetch_pc, so loading imem_addr holds the PC.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = fetch_valid_q;
        count_d       = count_q;
        if (state_q == FETCH_RUN) begin
            if (halt) begin
                fetch_valid_d = 1'b0;
            end else begin
                fetch_pc_d    = imem_addr;
                fetch_valid_d = 1'b1;
            end
            if (fetch_valid_q && !stall && !flush && !halt && !(&count_q))
                count_d = count_q + CNT_ONE;
        end else if (start) begin
            fetch_pc_d    = RESET_PC_V;
            fetch_valid_d = 1'b1;
            count_d       = '0;
        end else begin
            fetch_valid_d = 1'b0;
        end
    end

    assign fetch_pc    = fetch_pc_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. The driver applies one vector per cycle and
// queues the hand-computed outputs for that cycle; the monitor pops and checks
// on the falling edge. A second instance with a 2-bit counter shares the
// stimulus so counter saturation is exercised.
module tb_pc_fetch_unit;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         reset, start, halt, stall, branch_taken;
    logic [W-1:0] branch_target;
    logic [W-1:0] imem_addr, fetch_pc, imem_addr2, fetch_pc2;
    logic         fetch_valid, flush, running, fetch_valid2, flush2, running2;
    logic [31:0]  fetch_count;
    logic [1:0]   fetch_count2;

    typedef struct {
        logic [W-1:0] addr;
        logic         fl;
        logic         run;
        logic [W-1:0] pc;
        logic         v;
        logic [31:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    int   pushed = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.INST_ADDR_WIDTH(W), .RESET_PC(0), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
        .flush(flush), .running(running), .fetch_count(fetch_count)
    );

    pc_fetch_unit #(.INST_ADDR_WIDTH(W), .RESET_PC(0), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr2), .fetch_pc(fetch_pc2), .fetch_valid(fetch_valid2),
        .flush(flush2), .running(running2), .fetch_count(fetch_count2)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, req);
        end
    endtask

    // Monitor: compare every queued expectation against the DUT outputs
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [31:0] sat;
            e = exp_q.pop_front();
            sat = (e.cnt > 32'd3) ? 32'd3 : e.cnt;
            chk("imem_addr",   popped, 32'(imem_addr),    32'(e.addr));
            chk("flush",       popped, 32'(flush),        32'(e.fl));
            chk("running",     popped, 32'(running),      32'(e.run));
            chk("fetch_pc",    popped, 32'(fetch_pc),     32'(e.pc));
            chk("fetch_valid", popped, 32'(fetch_valid),  32'(e.v));
            chk("fetch_count", popped, fetch_count,       e.cnt);
            chk("sat_count",   popped, 32'(fetch_count2), sat);
            popped++;
        end
    end

    // One stimulus cycle: inputs rst,start,halt,stall,br,tgt then expected outputs
    task automatic cyc(input logic r, input logic s, input logic h, input logic sl,
                       input logic b, input logic [W-1:0] t,
                       input logic [W-1:0] ea, input logic ef, input logic er,
                       input logic [W-1:0] ep, input logic ev, input logic [31:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; start = s; halt = h; stall = sl; branch_taken = b; branch_target = t;
        e.addr = ea; e.fl = ef; e.run = er; e.pc = ep; e.v = ev; e.cnt = ec;
        exp_q.push_back(e);
        pushed++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        repeat (2) @(posedge clk);
        //   rst st hl sl br tgt       addr    fl run pc      v  cnt
        cyc(0, 0, 0, 0, 0, 9'h000,   9'h000, 0, 0, 9'h000, 0, 0);   // idle after reset
        cyc(0, 1, 0, 0, 0, 9'h000,   9'h000, 0, 0, 9'h000, 0, 0);   // start pulse
        cyc(0, 0, 0, 0, 0, 9'h000,   9'h001, 0, 1, 9'h000, 1, 0);
        cyc(0, 0, 0, 0, 0, 9'h000,   9'h002, 0, 1, 9'h001, 1, 1);
        cyc(0, 0, 0, 0, 0, 9'h000,   9'h003, 0, 1, 9'h002, 1, 2);
        cyc(0, 0, 0, 0, 0, 9'h000,   9'h004, 0, 1, 9'h003, 1, 3);
        cyc(0, 0, 0, 0, 0, 9'h000,   9'h005, 0, 1, 9'h004, 1, 4);
        cyc(0, 0, 0, 0, 1, 9'h120,   9'h120, 1, 1, 9'h005, 1, 5);   // branch, flush
        cyc(0, 0, 0, 0, 0, 9'h000,   9'h121, 0, 1, 9'h120, 1, 5);   // flushed slot not counted
        cyc(0, 0, 0, 0, 1, 9'h007,   9'h007, 1, 1, 9'h121, 1, 6);   // branch to 7
        cyc(0, 0, 0, 1, 0, 9'h000,   9'h007, 0, 1, 9'h007, 1, 6);   // stall x3
        cyc(0, 0, 0, 1, 0, 9'h000,   9'h007, 0, 1, 9'h007, 1, 6);
        cyc(0, 0, 0, 1, 0, 9'h000,   9'h007, 0, 1, 9'h007, 1, 6);
        cyc(0, 0, 0, 0, 0, 9'h000,   9'h008, 0, 1, 9'h007, 1, 6);   // release
        cyc(0, 0, 0, 1, 1, 9'h1FE,   9'h1FE, 1, 1, 9'h008, 1, 7);   // branch beats stall
        cyc(0, 1, 0, 0, 0, 9'h000,   9'h1FF, 0, 1, 9'h1FE, 1, 7);   // start in RUN ignored
        cyc(0, 0, 0, 0, 0, 9'h000,   9'h000, 0, 1, 9'h1FF, 1, 8);   // wrap address
        cyc(0, 0, 0, 0, 0, 9'h000,   9'h001, 0, 1, 9'h000, 1, 9);
        cyc(0, 0, 1, 1, 1, 9'h055,   9'h055, 0, 1, 9'h001, 1, 10);  // halt+branch+stall
        cyc(0, 0, 0, 0, 0, 9'h000,   9'h000, 0, 0, 9'h001, 0, 10);  // HALTED, pc frozen
        cyc(0, 1, 0, 0, 0, 9'h000,   9'h000, 0, 0, 9'h001, 0, 10);  // restart
        cyc(0, 0, 0, 0, 1, 9'h055,   9'h055, 1, 1, 9'h000, 1, 0);   // count cleared
        cyc(1, 0, 0, 0, 1, 9'h010,   9'h010, 1, 1, 9'h055, 1, 0);   // reset mid-RUN
        cyc(0, 0, 0, 0, 0, 9'h000,   9'h000, 0, 0, 9'h000, 0, 0);   // back to IDLE
        cyc(0, 0, 0, 0, 0, 9'h000,   9'h000, 0, 0, 9'h000, 0, 0);
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0 || popped != pushed) begin
            errors++;
            $display("FAIL drain: popped %0d expected %0d", popped, pushed);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
